bus_router: RTL
===============

BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 The block SHALL have parameter NSLV, default 4, meaning the number of slave ports (range 1..8).
REQ-002 The block SHALL have parameter SLV_BASE, default {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, meaning one 32-bit base per slave, with slave k at bits [32k+31:32k].
REQ-003 The block SHALL have parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hF000_0000}, meaning one 32-bit compare mask per slave, packed the same way as SLV_BASE.
REQ-004 The block SHALL have parameter TIMEOUT, default 256, meaning the number of WAIT cycles allowed before an error termination (minimum 2).
REQ-005 The block SHALL have these ports (reset rst is synchronous and active-low; clock is clk):
  clk  in  1  clock
  rst  in  1  synchronous reset, active-low
  m_valid  in  1  master request, held stable until m_ready
  m_instr  in  1  instruction-fetch qualifier
  m_addr  in  32  byte address
  m_wdata  in  32  write data
  m_wstrb  in  4  byte strobes (0 = read)
  m_rdata  out  32  read data
  m_ready  out  1  completion pulse
  m_error  out  1  error completion, valid only with m_ready
  s_valid  out  NSLV  per-slave request
  s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  broadcast copies of the m_* inputs
  s_rdata  in  32*NSLV  per-slave read data
  s_ready  in  NSLV  per-slave completion
  err_addr  out  32  address of the most recent error
  err_count  out  8  saturating error counter

Function
REQ-006 The block SHALL decode slave k as hit when (m_addr & MASK_k) == BASE_k; on multiple hits, the lowest index SHALL win.
REQ-007 The state machine SHALL have three states: IDLE, WAIT and ERR, and SHALL hold a registered slave select sel and a timeout counter cnt.
REQ-008 In IDLE with m_valid=1 and a hit on slave k: s_valid[k]=1 combinationally in the same cycle, sel<=k, cnt<=0.
REQ-009 In the REQ-008 case with s_ready[k]=1 in the same cycle: m_ready=1 and m_rdata=s_rdata[k] (zero-wait), and the state SHALL stay IDLE.
REQ-010 In the REQ-008 case with s_ready[k]=0: the state SHALL go to WAIT.
REQ-011 In IDLE with m_valid=1 and no hit: all s_valid SHALL be 0, and the next state SHALL be ERR.
REQ-012 In WAIT: s_valid[sel]=m_valid, all other s_valid SHALL be 0, m_rdata=s_rdata[sel], and m_ready=s_ready[sel].
REQ-013 In WAIT when s_ready[sel]=1, the next state SHALL be IDLE.
REQ-014 In WAIT without s_ready[sel]: if cnt==TIMEOUT-1 the next state SHALL be ERR, else cnt SHALL increment.
REQ-015 In ERR: m_ready=1, m_error=1, m_rdata=0 and all s_valid=0 for exactly one cycle, then the next state SHALL be IDLE.
REQ-016 On entry to ERR, err_addr SHALL load m_addr, and err_count SHALL increment, saturating at 255.
REQ-017 Outside REQ-009, REQ-012 and REQ-015, m_ready, m_error and m_rdata SHALL be 0.
REQ-018 s_ready or s_rdata from non-selected slaves SHALL be ignored.
REQ-019 In IDLE or WAIT, if the master drops m_valid before m_ready, the block SHALL continue WAIT on sel and SHALL deassert s_valid; the timeout SHALL still apply.
REQ-020 Decode-miss latency SHALL be 1 cycle; timeout termination SHALL arrive TIMEOUT+1 cycles after acceptance.

Reset
REQ-021 While rst=0 at a clk edge: state<=IDLE, sel<=0, cnt<=0, err_addr<=0, err_count<=0.
REQ-022 Combinational outputs SHALL follow the IDLE rules during reset.
REQ-023 A reset asserted mid-transaction SHALL abandon the transaction without issuing m_ready.

Verification
REQ-024 Zero-wait case: TIMEOUT=256, m_addr=32'h1000_0010 read, s_ready[1]=1 in the same cycle with rdata 32'hCAFE_0001 -> in that cycle s_valid=4'b0010, m_ready=1, m_rdata=32'hCAFE_0001, m_error=0.
REQ-025 Wait-state case: m_addr=32'h0000_0100, s_ready[0] rises 3 cycles after acceptance -> m_ready in that cycle, and s_valid[0]=1 on every cycle from acceptance through completion.
REQ-026 Decode miss: m_addr=32'h8000_0000 -> next cycle m_ready=1, m_error=1, m_rdata=0; err_addr=32'h8000_0000, err_count=1; no s_valid ever asserted.
REQ-027 Timeout: TIMEOUT=4, slave 2 never ready -> WAIT in cycles 1-4, ERR at cycle 5 with m_ready=1 and m_error=1, s_valid=0 in cycle 5.
REQ-028 Overlap and saturation: BASE1 equal to BASE0 -> slave 0 selected; 300 decode misses -> err_count=255.
REQ-029 Reset mid-WAIT: rst=0 at cycle 2 of WAIT -> state IDLE, err_count=0, no m_ready pulse.

Source files
------------

// File: rtl/bus_router.sv
// bus_router: address-decoding single-master to NSLV-slave router with wait states, timeout and error logging
module bus_router #(
  parameter int NSLV = 4,
  parameter logic [32*NSLV-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NSLV-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hF000_0000},
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_instr,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  input  logic [3:0]        m_wstrb,
  output logic [31:0]       m_rdata,
  output logic              m_ready,
  output logic              m_error,
  output logic [NSLV-1:0]   s_valid,
  output logic              s_instr,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [32*NSLV-1:0] s_rdata,
  input  logic [NSLV-1:0]   s_ready,
  output logic [31:0]       err_addr,
  output logic [7:0]        err_count
);
  localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;
  logic [1:0]    state_q, state_d, st;
  logic [SW-1:0] sel_q, sel_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          hit, enter_err;
  assign s_instr   = m_instr;
  assign s_addr    = m_addr;
  assign s_wdata   = m_wdata;
  assign s_wstrb   = m_wstrb;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
  // While reset is held, outputs behave as if the FSM were already idle
  assign st = rst ? state_q : IDLE;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NSLV - 1; k >= 0; k--)
      if ((m_addr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
        hit = 1'b1;
        idx = SW'(k);
      end
  end
  always_comb begin
    s_valid     = '0;
    m_ready     = 1'b0;
    m_error     = 1'b0;
    m_rdata     = '0;
    state_d     = st;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    enter_err   = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (st == IDLE) begin
      if (m_valid && hit) begin
        s_valid = NSLV'(1) << idx;
        sel_d   = idx;
        cnt_d   = '0;
        if (s_ready[idx]) begin
          m_ready = 1'b1;
          m_rdata = s_rdata[32*idx +: 32];
        end else begin
          state_d = WAIT;
        end
      end else if (m_valid) begin
        enter_err = 1'b1;
      end
    end else if (st == WAIT) begin
      s_valid = m_valid ? NSLV'(1) << sel_q : '0;
      m_rdata = s_rdata[32*sel_q +: 32];
      m_ready = s_ready[sel_q];
      if (s_ready[sel_q])
        state_d = IDLE;
      else if (cnt_q == CW'(TIMEOUT - 1))
        enter_err = 1'b1;
      else
        cnt_d = cnt_q + 1'b1;
    end else begin
      m_ready = 1'b1;
      m_error = 1'b1;
      state_d = IDLE;
    end
    if (enter_err) begin
      state_d     = ERR;
      err_addr_d  = m_addr;
      err_count_d = err_count_q + {7'd0, err_count_q != 8'hFF};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end
endmodule
